// File: rtl/riscv_core_top.sv
// Single-cycle RV32I core executing OP / OP-IMM from a fixed instruction ROM.
// Optional macro RISCV_ILLEGAL_HALT_EN: an illegal instruction halts the core until reset.
`timescale 1ns/1ps
module riscv_core_top #(
   parameter int WIDTH      = 32,
   parameter int IMEM_DEPTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] rd
);
   localparam int AW = $clog2(IMEM_DEPTH);
   localparam logic [6:0] OPC_OP  = 7'b0110011;
   localparam logic [6:0] OPC_IMM = 7'b0010011;

   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_next;
   logic [WIDTH-1:0] regs [32];
   logic [31:0]      inst;
   logic [6:0]       opcode;
   logic [6:0]       funct7;
   logic [2:0]       funct3;
   logic [4:0]       rs1_addr;
   logic [4:0]       rs2_addr;
   logic [4:0]       rd_addr;
   logic             is_op;
   logic             is_imm;
   logic             legal;
   logic signed [WIDTH-1:0] op_a;
   logic signed [WIDTH-1:0] op_b;
   logic signed [WIDTH-1:0] alu;
   logic [4:0]       shamt;
   logic [WIDTH-1:0] wb;

   function automatic logic [31:0] rom_word(input logic [AW-1:0] addr);
      logic [31:0] idx;
      idx = 32'(addr);
      case (idx)
         32'd0:   rom_word = 32'h00a08093;
         32'd1:   rom_word = 32'h00a10113;
         32'd2:   rom_word = 32'h002081b3;
         32'd3:   rom_word = 32'h00312233;
         32'd4:   rom_word = 32'h0010d293;
         32'd5:   rom_word = 32'h00211313;
         32'd6:   rom_word = 32'h0032f3b3;
         32'd7:   rom_word = 32'h0032e433;
         32'd8:   rom_word = 32'h0032c4b3;
         32'd9:   rom_word = 32'h40610533;
         32'd10:  rom_word = 32'h004155b3;
         32'd11:  rom_word = 32'h00411633;
         32'd12:  rom_word = 32'h40555693;
         32'd13:  rom_word = 32'h40555733;
         default: rom_word = 32'h00000013;
      endcase
   endfunction

   assign inst     = rom_word(pc[AW+1:2]);
   assign opcode   = inst[6:0];
   assign rd_addr  = inst[11:7];
   assign funct3   = inst[14:12];
   assign rs1_addr = inst[19:15];
   assign rs2_addr = inst[24:20];
   assign funct7   = inst[31:25];
   assign is_op    = (opcode == OPC_OP);
   assign is_imm   = (opcode == OPC_IMM);

   // funct7 may only carry bit 30, and only for SUB and the arithmetic right shifts
   always_comb begin
      legal = 1'b0;
      if (is_op) begin
         legal = (funct7 == 7'b0000000) ||
                 ((funct7 == 7'b0100000) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
      end else if (is_imm) begin
         case (funct3)
            3'd1:    legal = (funct7 == 7'b0000000);
            3'd5:    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            default: legal = 1'b1;
         endcase
      end
   end

   assign op_a  = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
   assign op_b  = is_op ? ((rs2_addr == 5'd0) ? '0 : regs[rs2_addr])
                        : {{(WIDTH-12){inst[31]}}, inst[31:20]};
   assign shamt = op_b[4:0];

   always_comb begin
      alu = '0;
      case (funct3)
         3'd0: alu = (is_op && funct7[5]) ? op_a - op_b : op_a + op_b;
         3'd1: alu = op_a << shamt;
         3'd2: alu = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
         3'd3: alu = {{(WIDTH-1){1'b0}}, ($unsigned(op_a) < $unsigned(op_b))};
         3'd4: alu = op_a ^ op_b;
         3'd5: alu = funct7[5] ? (op_a >>> shamt) : (op_a >> shamt);
         3'd6: alu = op_a | op_b;
         3'd7: alu = op_a & op_b;
         default: alu = '0;
      endcase
   end

   assign wb      = (legal && (rd_addr != 5'd0)) ? alu : '0;
   assign pc_next = (pc == WIDTH'((IMEM_DEPTH - 1) * 4)) ? '0 : pc + WIDTH'(4);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= '0;
         rd <= '0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
`ifdef RISCV_ILLEGAL_HALT_EN
         if (legal) begin
            pc <= pc_next;
            rd <= wb;
         end
`else
         pc <= pc_next;
         rd <= wb;
`endif
         if (legal && (rd_addr != 5'd0)) regs[rd_addr] <= alu;
      end
   end
endmodule

// File: tb/tb_riscv_core_top.sv
// Bench for riscv_core_top: directed program checks plus random async resets,
// compared against an instruction-level model of the ROM program.
`timescale 1ns/1ps
module tb_riscv_core_top;
   localparam int WIDTH = 32;
   localparam int DEPTH = 64;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] rd;

   riscv_core_top #(.WIDTH(WIDTH), .IMEM_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .rd  (rd)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] prog [14] = '{
      32'h00a08093, 32'h00a10113, 32'h002081b3, 32'h00312233,
      32'h0010d293, 32'h00211313, 32'h0032f3b3, 32'h0032e433,
      32'h0032c4b3, 32'h40610533, 32'h004155b3, 32'h00411633,
      32'h40555693, 32'h40555733 };

   logic [31:0] golden [14] = '{
      32'h0000000a, 32'h0000000a, 32'h00000014, 32'h00000001,
      32'h00000005, 32'h00000028, 32'h00000004, 32'h00000015,
      32'h00000011, 32'hffffffe2, 32'h00000005, 32'h00000014,
      32'hffffffff, 32'hffffffff };

   // architectural state of the reference model
   int unsigned m_pc;
   logic [31:0] m_x [32];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0;
      for (int i = 0; i < 32; i++) m_x[i] = 32'h0;
   endtask

   task automatic model_step(output logic [31:0] res);
      logic [31:0] inst, a, b, r;
      logic [6:0]  opc, f7;
      logic [2:0]  f3;
      logic [4:0]  dst;
      int unsigned sh;
      bit ok;
      inst = (m_pc / 4 < 14) ? prog[m_pc / 4] : 32'h00000013;
      opc  = inst[6:0];
      dst  = inst[11:7];
      f3   = inst[14:12];
      f7   = inst[31:25];
      a    = m_x[inst[19:15]];
      b    = (opc == 7'h33) ? m_x[inst[24:20]] : {{20{inst[31]}}, inst[31:20]};
      sh   = b % 32;
      ok   = (opc == 7'h33) || (opc == 7'h13);
      r    = 32'h0;
      if (ok) begin
         if (f3 == 3'd0)      r = (opc == 7'h33 && f7 == 7'h20) ? a - b : a + b;
         else if (f3 == 3'd1) r = a << sh;
         else if (f3 == 3'd2) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         else if (f3 == 3'd3) r = (a < b) ? 32'd1 : 32'd0;
         else if (f3 == 3'd4) r = a ^ b;
         else if (f3 == 3'd5) r = (f7 == 7'h20) ? 32'($signed(a) >>> sh) : a >> sh;
         else if (f3 == 3'd6) r = a | b;
         else                 r = a & b;
      end
      if (ok && dst != 5'd0) begin
         m_x[dst] = r;
         res = r;
      end else begin
         res = 32'h0;
      end
      m_pc = (m_pc + 4) % (DEPTH * 4);
   endtask

   // one rising edge, then compare rd on the following falling edge
   task automatic tick(input string tag, output logic [31:0] obs);
      logic [31:0] e;
      @(posedge clk);
      model_step(e);
      @(negedge clk);
      obs = rd;
      check(tag, obs, e);
   endtask

   // called just after a falling edge; asserts reset mid-cycle, releases a cycle later
   task automatic async_reset(input int unsigned off);
      #(off);
      rst = 1'b0;
      #1;
      check("async_rst_clear", rd, 32'h0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      check("rst_hold", rd, 32'h0);
      rst = 1'b1;
   endtask

   initial begin
      logic [31:0] obs;
      model_reset();
      #1 rst = 1'b0;
      #1 check("reset_immediate", rd, 32'h0);
      @(negedge clk);
      check("reset_hold_1", rd, 32'h0);
      @(negedge clk);
      check("reset_hold_2", rd, 32'h0);
      rst = 1'b1;

      // first pass through the program, then the NOP tail and the wrap
      for (int k = 0; k < 14; k++) begin
         tick("prog_model", obs);
         check("prog_golden", obs, golden[k]);
      end
      for (int k = 14; k < DEPTH; k++) begin
         tick("nop_model", obs);
         check("nop_zero", obs, 32'h0);
      end
      tick("wrap_model", obs);
      check("wrap_x1_20", obs, 32'h00000014);
      for (int k = 0; k < 13; k++) tick("second_pass", obs);

      // reset landing between edges 6 and 7, then a clean restart
      async_reset(2);
      for (int k = 0; k < 6; k++) tick("pre_mid_rst", obs);
      async_reset(3);
      for (int k = 0; k < 4; k++) begin
         tick("restart_model", obs);
         check("restart_golden", obs, golden[k]);
      end

      // random run lengths broken by random asynchronous resets
      for (int t = 0; t < 20; t++) begin
         int unsigned n;
         n = $urandom_range(1, 90);
         for (int k = 0; k < int'(n); k++) tick("rand_run", obs);
         async_reset($urandom_range(1, 3));
      end
      for (int k = 0; k < 14; k++) begin
         tick("final_model", obs);
         check("final_golden", obs, golden[k]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/riscv_core_top.md
Name: riscv_core_top

Overview:
- Single-cycle RV32I integer core: PC, fixed-content instruction ROM, 32x32 register file, ALU, writeback.
- Executes the R-type (OP) and I-type ALU (OP-IMM) instruction subset only.
- Exposes the registered writeback value of each retired instruction on `rd`; this is the only observation point for system-level benches.

Parameters:
- WIDTH, 32, datapath/register width; only 32 is functionally required.
- IMEM_DEPTH, 64, instruction ROM depth in 32-bit words; PC wraps modulo IMEM_DEPTH*4.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted at 0).
- rd  output  WIDTH  registered writeback value of the instruction retired on the last rising edge.

Behaviour:
- Reset (rst=0, asynchronous): PC=0, x0..x31=0, rd=0; all held while asserted.
- Each rising edge (rst=1):
  - Fetch imem[PC[log2(IMEM_DEPTH)+1:2]], decode, execute, write back.
  - PC <= PC+4, wrapping to 0 after the last ROM word.
  - rd <= writeback value of that instruction.
- Latency: instruction at PC=4k appears on rd after edge k+1 following reset release.
- ROM contents (hex, word address 0..13):
  - 00a08093 ADDI x1,x1,10
  - 00a10113 ADDI x2,x2,10
  - 002081b3 ADD x3,x1,x2
  - 00312233 SLT x4,x2,x3
  - 0010d293 SRLI x5,x1,1
  - 00211313 SLLI x6,x2,2
  - 0032f3b3 AND x7,x5,x3
  - 0032e433 OR x8,x5,x3
  - 0032c4b3 XOR x9,x5,x3
  - 40610533 SUB x10,x2,x6
  - 004155b3 SRL x11,x2,x4
  - 00411633 SLL x12,x2,x4
  - 40555693 SRAI x13,x10,5
  - 40555733 SRA x14,x10,x5
  - All remaining words 00000013 (NOP).
- OP (opcode 0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND per funct3/funct7[5].
- OP-IMM (opcode 0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - Immediate = inst[31:20], sign-extended.
  - SRAI is selected by inst[30].
- Arithmetic rules:
  - Add/sub wrap modulo 2^32.
  - Shift amount = low 5 bits of rs2 or immediate.
  - SRA/SRAI replicate bit 31.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned, immediate sign-extended before the compare; result 0 or 1.
- Register file:
  - Two combinational read ports; x0 always reads 0.
  - Write to x0 is discarded and rd shows 0.
  - Read-after-write across consecutive instructions is resolved by the edge write; no bypass needed.
- Any other opcode: no register write, rd <= 0, PC advances.
- Reset mid-program: state clears immediately; execution restarts at PC=0 on first edge after release.

Optional Feature:
- Macro RISCV_ILLEGAL_HALT_EN.
- Defined: an unsupported opcode, or an illegal funct7 on OP/shift-immediate, freezes PC (halt) and holds rd and registers until reset.
- Undefined: such instructions execute as NOPs (rd <= 0, PC+4).

Test Plan:
- Hold rst=0 for 20 ns with clk toggling -> rd=0, PC=0, no register changes; release -> first edge gives rd=0000000a.
- Run edges 1..9 -> rd sequence 0a, 0a, 14, 01, 05, 28, 04, 15, 11 (hex).
- Edges 10..14 -> rd = ffffffe2, 00000005, 00000014, ffffffff, ffffffff; final x10=ffffffe2, x13=x14=ffffffff.
- Edges 15..IMEM_DEPTH -> rd=0 (NOPs); edge IMEM_DEPTH+1 -> PC wraps, rd=00000014 (x1 becomes 20).
- Assert rst=0 asynchronously between edges 6 and 7 -> rd and all registers 0 immediately; after release, sequence restarts at rd=0000000a.
- With RISCV_ILLEGAL_HALT_EN, force ROM word 14 = 0000007f -> after edge 14 PC stays 0x38 and rd holds ffffffff; without the macro, rd=0 and PC advances.
